// File: rtl/cpu7_excp_ctrl_pkg.sv
// Shared types and constants for the exception/ERTN sequencer.
// CSR addresses, PRMD field layout and FSM state encodings.
package cpu7_excp_ctrl_pkg;

   localparam int GRLEN   = 32;
   localparam int CSR_BIT = 14;

   localparam logic [CSR_BIT-1:0] CSR_CRMD  = 14'h000;
   localparam logic [CSR_BIT-1:0] CSR_PRMD  = 14'h001;
   localparam logic [CSR_BIT-1:0] CSR_EPC   = 14'h006;
   localparam logic [CSR_BIT-1:0] CSR_EBASE = 14'h00c;

   localparam int PRMD_PIE     = 2;
   localparam int PRMD_PPLV_HI = 1;
   localparam int PRMD_PPLV_LO = 0;

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_EX_ERA  = 3'd1,
      S_EX_CRMD = 3'd2,
      S_EX_JMP  = 3'd3,
      S_RT_CRMD = 3'd4,
      S_RT_JMP  = 3'd5
   } excp_state_t;

   typedef struct packed {
      logic [CSR_BIT-1:0] raddr;
      logic [CSR_BIT-1:0] waddr;
      logic [GRLEN-1:0]   wdata;
      logic               wen;
   } csr_port_t;

   function automatic logic [GRLEN-1:0] crmd_from_prmd(input logic [2:0] p);
      return {{(GRLEN-3){1'b0}}, p};
   endfunction

endpackage

// File: rtl/cpu7_excp_ctrl_if.sv
// CSR register file port: one read, one write, plus EENTRY.
// master = port owner (sequencer), slave = CSR file.
interface cpu7_excp_ctrl_if;
   import cpu7_excp_ctrl_pkg::*;

   logic [CSR_BIT-1:0] csr_raddr;
   logic [CSR_BIT-1:0] csr_waddr;
   logic [GRLEN-1:0]   csr_wdata;
   logic               csr_wen;
   logic [GRLEN-1:0]   csr_rdata;
   logic [GRLEN-1:0]   csr_eentry;

   modport master (
      output csr_raddr, csr_waddr, csr_wdata, csr_wen,
      input  csr_rdata, csr_eentry
   );

   modport slave (
      input  csr_raddr, csr_waddr, csr_wdata, csr_wen,
      output csr_rdata, csr_eentry
   );

endinterface

// File: rtl/cpu7_csr_wport_mux.sv
// 2:1 CSR port mux, pipeline vs. sequencer.
// Read and write sides select independently.
module cpu7_csr_wport_mux
   import cpu7_excp_ctrl_pkg::*;
(
   input  logic      wsel,
   input  logic      rsel,
   input  csr_port_t pipe,
   input  csr_port_t seq,
   output csr_port_t port
);

   always_comb begin
      port       = wsel ? seq : pipe;
      port.raddr = rsel ? seq.raddr : pipe.raddr;
   end

endmodule

// File: rtl/cpu7_excp_ctrl.sv
// Exception/ERTN sequencer owning the CSR file ports.
// Saves ERA/PRMD, clears CRMD, redirects; ERTN restores and returns.
module cpu7_excp_ctrl
   import cpu7_excp_ctrl_pkg::*;
(
   input  logic               clk,
   input  logic               reset,
   input  logic               excp_req,
   input  logic [GRLEN-1:0]   excp_pc,
   input  logic [5:0]         excp_ecode,
   input  logic               ertn_req,
   input  logic [CSR_BIT-1:0] pipe_csr_raddr,
   input  logic [CSR_BIT-1:0] pipe_csr_waddr,
   input  logic [GRLEN-1:0]   pipe_csr_wdata,
   input  logic               pipe_csr_wen,
   cpu7_excp_ctrl_if.master   csr,
   output logic               redirect_valid,
   output logic [GRLEN-1:0]   redirect_pc,
   output logic               pipe_stall,
   output logic [2:0]         prmd,
   output logic [5:0]         ecode_q
);

   excp_state_t      state, state_nxt;
   logic [GRLEN-1:0] pc_q, tgt_q;
   logic             wsel, rsel;
   csr_port_t        pipe_port, seq_port, mux_port;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= S_IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      unique case (state)
         S_IDLE: begin
            if (excp_req)      state_nxt = S_EX_ERA;
            else if (ertn_req) state_nxt = S_RT_CRMD;
         end
         S_EX_ERA:  state_nxt = S_EX_CRMD;
         S_EX_CRMD: state_nxt = S_EX_JMP;
         S_EX_JMP:  state_nxt = S_IDLE;
         S_RT_CRMD: state_nxt = S_RT_JMP;
         S_RT_JMP:  state_nxt = S_IDLE;
         default:   state_nxt = S_IDLE;
      endcase
   end

   always_comb begin
      wsel           = (state != S_IDLE);
      rsel           = 1'b0;
      seq_port       = '0;
      redirect_valid = 1'b0;
      redirect_pc    = '0;
      unique case (state)
         S_EX_ERA: begin
            seq_port.wen   = 1'b1;
            seq_port.waddr = CSR_EPC;
            seq_port.wdata = pc_q;
            rsel           = 1'b1;
            seq_port.raddr = CSR_CRMD;
         end
         S_EX_CRMD: begin
            seq_port.wen   = 1'b1;
            seq_port.waddr = CSR_CRMD;
         end
         S_EX_JMP: begin
            redirect_valid = 1'b1;
            redirect_pc    = csr.csr_eentry;
         end
         S_RT_CRMD: begin
            seq_port.wen   = 1'b1;
            seq_port.waddr = CSR_CRMD;
            seq_port.wdata = crmd_from_prmd(prmd);
            rsel           = 1'b1;
            seq_port.raddr = CSR_EPC;
         end
         S_RT_JMP: begin
            redirect_valid = 1'b1;
            redirect_pc    = tgt_q;
         end
         default: ;
      endcase
      pipe_stall = (state != S_IDLE) | excp_req | ertn_req;
   end

   // An exception squashes a pipe write in the same cycle
   always_comb begin
      pipe_port.raddr = pipe_csr_raddr;
      pipe_port.waddr = pipe_csr_waddr;
      pipe_port.wdata = pipe_csr_wdata;
      pipe_port.wen   = pipe_csr_wen & ~excp_req;
   end

   cpu7_csr_wport_mux u_mux (
      .wsel (wsel),
      .rsel (rsel),
      .pipe (pipe_port),
      .seq  (seq_port),
      .port (mux_port)
   );

   assign csr.csr_raddr = mux_port.raddr;
   assign csr.csr_waddr = mux_port.waddr;
   assign csr.csr_wdata = mux_port.wdata;
   assign csr.csr_wen   = mux_port.wen;

   wire accept_excp = (state == S_IDLE) & excp_req;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pc_q    <= '0;
         ecode_q <= '0;
      end else if (accept_excp) begin
         pc_q    <= excp_pc;
         ecode_q <= excp_ecode;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset)                   prmd <= '0;
      else if (state == S_EX_ERA)  prmd <= csr.csr_rdata[2:0];
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset)                   tgt_q <= '0;
      else if (state == S_RT_CRMD) tgt_q <= csr.csr_rdata;
   end

endmodule

// File: tb/tb_cpu7_excp_ctrl.sv
// Directed bench for cpu7_excp_ctrl with a small CSR file model.
// Inputs change on negedge; outputs are checked 1ns later.
module tb_cpu7_excp_ctrl;
   import cpu7_excp_ctrl_pkg::*;

   logic               clk = 1'b0;
   logic               reset;
   logic               excp_req, ertn_req;
   logic [GRLEN-1:0]   excp_pc;
   logic [5:0]         excp_ecode;
   logic [CSR_BIT-1:0] pipe_csr_raddr, pipe_csr_waddr;
   logic [GRLEN-1:0]   pipe_csr_wdata;
   logic               pipe_csr_wen;
   logic               redirect_valid, pipe_stall;
   logic [GRLEN-1:0]   redirect_pc;
   logic [2:0]         prmd;
   logic [5:0]         ecode_q;
   logic               init_mem;
   logic [GRLEN-1:0]   mem [0:15];
   int                 errors = 0;
   int                 checks = 0;

   cpu7_excp_ctrl_if csr_if ();

   cpu7_excp_ctrl dut (
      .clk            (clk),
      .reset          (reset),
      .excp_req       (excp_req),
      .excp_pc        (excp_pc),
      .excp_ecode     (excp_ecode),
      .ertn_req       (ertn_req),
      .pipe_csr_raddr (pipe_csr_raddr),
      .pipe_csr_waddr (pipe_csr_waddr),
      .pipe_csr_wdata (pipe_csr_wdata),
      .pipe_csr_wen   (pipe_csr_wen),
      .csr            (csr_if),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .pipe_stall     (pipe_stall),
      .prmd           (prmd),
      .ecode_q        (ecode_q)
   );

   always #5 clk = ~clk;

   assign csr_if.csr_rdata  = mem[csr_if.csr_raddr[3:0]];
   assign csr_if.csr_eentry = mem[CSR_EBASE[3:0]];

   always @(posedge clk) begin
      if (init_mem) begin
         for (int i = 0; i < 16; i++) mem[i] <= '0;
         mem[CSR_CRMD[3:0]] <= 32'h7;
      end else if (csr_if.csr_wen) begin
         mem[csr_if.csr_waddr[3:0]] <= csr_if.csr_wdata;
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(negedge clk);
   endtask

   task automatic settle();
      #1;
   endtask

   initial begin
      reset = 1'b1; init_mem = 1'b1;
      excp_req = 0; ertn_req = 0; excp_pc = '0; excp_ecode = '0;
      pipe_csr_raddr = '0; pipe_csr_waddr = '0;
      pipe_csr_wdata = '0; pipe_csr_wen = 0;
      repeat (3) step();
      reset = 1'b0; init_mem = 1'b0;
      settle();
      chk("rst_redirect", 32'(redirect_valid), 0);
      chk("rst_stall", 32'(pipe_stall), 0);
      chk("rst_prmd", 32'(prmd), 0);
      chk("rst_ecode", 32'(ecode_q), 0);
      chk("rst_wen", 32'(csr_if.csr_wen), 0);

      // pipe write to EBASE with no request: forwarded
      step();
      pipe_csr_wen = 1; pipe_csr_waddr = CSR_EBASE;
      pipe_csr_wdata = 32'h1C000100; pipe_csr_raddr = CSR_PRMD;
      settle();
      chk("fwd_wen", 32'(csr_if.csr_wen), 1);
      chk("fwd_waddr", 32'(csr_if.csr_waddr), 32'(CSR_EBASE));
      chk("fwd_wdata", csr_if.csr_wdata, 32'h1C000100);
      chk("fwd_raddr", 32'(csr_if.csr_raddr), 32'(CSR_PRMD));
      chk("fwd_stall", 32'(pipe_stall), 0);

      // exception with same-cycle pipe write, held through the sequence
      step();
      pipe_csr_wdata = 32'hDEAD0000;
      excp_req = 1; excp_pc = 32'h1C000040; excp_ecode = 6'h0B;
      settle();
      chk("ebase_written", mem[CSR_EBASE[3:0]], 32'h1C000100);
      chk("t0_wen_drop", 32'(csr_if.csr_wen), 0);
      chk("t0_stall", 32'(pipe_stall), 1);
      step();
      excp_req = 0; excp_pc = '0; excp_ecode = '0;
      settle();
      chk("t1_wen", 32'(csr_if.csr_wen), 1);
      chk("t1_waddr", 32'(csr_if.csr_waddr), 32'(CSR_EPC));
      chk("t1_wdata", csr_if.csr_wdata, 32'h1C000040);
      chk("t1_raddr", 32'(csr_if.csr_raddr), 32'(CSR_CRMD));
      chk("t1_stall", 32'(pipe_stall), 1);
      step(); settle();
      chk("t2_era", mem[CSR_EPC[3:0]], 32'h1C000040);
      chk("t2_prmd", 32'(prmd), 32'h7);
      chk("t2_ecode", 32'(ecode_q), 32'h0B);
      chk("t2_wen", 32'(csr_if.csr_wen), 1);
      chk("t2_waddr", 32'(csr_if.csr_waddr), 32'(CSR_CRMD));
      chk("t2_wdata", csr_if.csr_wdata, 0);
      chk("t2_stall", 32'(pipe_stall), 1);
      step(); settle();
      chk("t3_crmd", mem[CSR_CRMD[3:0]], 0);
      chk("t3_redir", 32'(redirect_valid), 1);
      chk("t3_pc", redirect_pc, 32'h1C000100);
      chk("t3_wen", 32'(csr_if.csr_wen), 0);
      chk("t3_stall", 32'(pipe_stall), 1);
      step();
      pipe_csr_wen = 0;
      settle();
      chk("t4_stall", 32'(pipe_stall), 0);
      chk("t4_redir", 32'(redirect_valid), 0);
      chk("ebase_kept", mem[CSR_EBASE[3:0]], 32'h1C000100);

      // ERTN
      step();
      ertn_req = 1;
      settle();
      chk("r0_stall", 32'(pipe_stall), 1);
      step();
      ertn_req = 0;
      settle();
      chk("r1_wen", 32'(csr_if.csr_wen), 1);
      chk("r1_waddr", 32'(csr_if.csr_waddr), 32'(CSR_CRMD));
      chk("r1_wdata", csr_if.csr_wdata, 32'h7);
      chk("r1_raddr", 32'(csr_if.csr_raddr), 32'(CSR_EPC));
      step(); settle();
      chk("r2_redir", 32'(redirect_valid), 1);
      chk("r2_pc", redirect_pc, 32'h1C000040);
      chk("r2_crmd", mem[CSR_CRMD[3:0]], 32'h7);
      step(); settle();
      chk("r3_stall", 32'(pipe_stall), 0);

      // simultaneous excp + ertn: exception wins
      step();
      excp_req = 1; ertn_req = 1;
      excp_pc = 32'h1C000080; excp_ecode = 6'h01;
      settle();
      step();
      excp_req = 0; ertn_req = 0;
      settle();
      chk("b1_waddr", 32'(csr_if.csr_waddr), 32'(CSR_EPC));
      chk("b1_wdata", csr_if.csr_wdata, 32'h1C000080);
      step(); settle();
      chk("b2_waddr", 32'(csr_if.csr_waddr), 32'(CSR_CRMD));
      chk("b2_wdata", csr_if.csr_wdata, 0);
      chk("b2_ecode", 32'(ecode_q), 32'h01);
      step(); settle();
      chk("b3_pc", redirect_pc, 32'h1C000100);
      // back-to-back ERTN right after the redirect cycle
      step();
      ertn_req = 1;
      settle();
      chk("b4_wen", 32'(csr_if.csr_wen), 0);
      chk("b4_redir", 32'(redirect_valid), 0);
      step();
      ertn_req = 0;
      settle();
      chk("b5_waddr", 32'(csr_if.csr_waddr), 32'(CSR_CRMD));
      chk("b5_wdata", csr_if.csr_wdata, 32'h7);
      step(); settle();
      chk("b6_redir", 32'(redirect_valid), 1);
      chk("b6_pc", redirect_pc, 32'h1C000080);

      // reset while in EX_CRMD
      step();
      excp_req = 1; excp_pc = 32'h1C0000C0; excp_ecode = 6'h02;
      step();
      excp_req = 0;
      step();
      reset = 1'b1;
      settle();
      chk("x_redir", 32'(redirect_valid), 0);
      chk("x_wen", 32'(csr_if.csr_wen), 0);
      chk("x_prmd", 32'(prmd), 0);
      chk("x_stall", 32'(pipe_stall), 0);
      step();
      reset = 1'b0;
      settle();
      chk("x_idle_stall", 32'(pipe_stall), 0);
      chk("x_ecode", 32'(ecode_q), 0);
      step(); settle();
      chk("x_redir2", 32'(redirect_valid), 0);
      chk("x_crmd", mem[CSR_CRMD[3:0]], 32'h7);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #20000;
      $display("FAIL timeout: observed no end, expected finish");
      $fatal(1, "timeout");
   end

endmodule
